mtr_ramp_ctrl: RTL and testbench



---
 rtl/mtr_pkg.sv | 32 +++
 rtl/mtr_slew.sv | 74 +++++++
 rtl/mtr_ramp_ctrl.sv | 104 ++++++++++
 tb/tb_mtr_ramp_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and defaults for the motor speed ramp controller.
// Latency: n/a (types, constants and a combinational clamp helper only).
// Backpressure: n/a.
package mtr_pkg;

    localparam int SPD_W           = 11;
    localparam int PERIOD_DEF      = 2048;
    localparam int STEP_DEF        = 16;
    localparam int BRK_STEP_DEF    = 64;
    localparam int SPD_LIM_DEF     = 1000;
    localparam int DWELL_TICKS_DEF = 4;

    typedef logic signed [SPD_W-1:0] spd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } ramp_state_t;

    // Symmetric magnitude clamp of a raw target to +/-lim.
    function automatic spd_t spd_clamp(input spd_t v, input int lim);
        if (int'(v) > lim) begin
            return spd_t'(lim);
        end
        if (int'(v) < -lim) begin
            return spd_t'(-lim);
        end
        return v;
    endfunction

endpackage

// File: rtl/mtr_slew.sv
// Per-wheel clamp, rate limiter and zero-speed dwell on reversal.
// Latency: cur updates only on the clock edge of a tick cycle.
// Backpressure: none; target is a level sampled on the tick cycle.
module mtr_slew
    import mtr_pkg::*;
#(
    parameter int STEP        = STEP_DEF,
    parameter int BRK_STEP    = BRK_STEP_DEF,
    parameter int SPD_LIM     = SPD_LIM_DEF,
    parameter int DWELL_TICKS = DWELL_TICKS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  ramp_state_t mode,
    input  spd_t        target,
    output spd_t        cur
);

    localparam int DW_W = $clog2(DWELL_TICKS + 1);

    // One extra bit so target - cur cannot overflow.
    typedef logic signed [SPD_W:0] wide_t;

    spd_t            cur_q, cur_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    spd_t            goal;
    wide_t           step, diff, ramp;

    // Next speed: step toward the goal, stop at 0 on a sign change, hold 0 while dwelling.
    always_comb begin
        goal = (mode == BRAKE) ? spd_t'(0) : spd_clamp(target, SPD_LIM);
        step = (mode == BRAKE) ? wide_t'(BRK_STEP) : wide_t'(STEP);
        diff = wide_t'(goal) - wide_t'(cur_q);
        if (diff <= step && diff >= -step) begin
            ramp = wide_t'(goal);
        end else if (diff > 0) begin
            ramp = wide_t'(cur_q) + step;
        end else begin
            ramp = wide_t'(cur_q) - step;
        end

        cur_d   = cur_q;
        dwell_d = dwell_q;
        if (tick) begin
            if (dwell_q != '0) begin
                dwell_d = dwell_q - DW_W'(1);
            end else if (mode != IDLE) begin
                if ((cur_q > 0 && ramp < 0) || (cur_q < 0 && ramp > 0)) begin
                    cur_d = '0;
                end else begin
                    cur_d = spd_t'(ramp);
                end
                if (cur_q != '0 && cur_d == '0) begin
                    dwell_d = DW_W'(DWELL_TICKS);
                end
            end
        end
    end

    // Speed and dwell registers; reset drops straight to 0 with no braking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            dwell_q <= '0;
        end else begin
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
        end
    end

    assign cur = cur_q;

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Speed sequencer: rate-limited, clamped wheel speeds with reversal dwell and brake-to-stop.
// Latency: a target change reaches the outputs at the next tick edge (1..PERIOD cycles).
// Backpressure: none; all inputs are levels, outputs are registered.
module mtr_ramp_ctrl
    import mtr_pkg::*;
#(
    parameter int PERIOD      = PERIOD_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int BRK_STEP    = BRK_STEP_DEF,
    parameter int SPD_LIM     = SPD_LIM_DEF,
    parameter int DWELL_TICKS = DWELL_TICKS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mtr_en,
    input  logic                    estop,
    input  logic signed [SPD_W-1:0] tgt_lft,
    input  logic signed [SPD_W-1:0] tgt_rght,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    at_target,
    output logic                    stopped,
    output logic                    estop_lat
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    ramp_state_t      state_q, state_d;
    logic             at_target_q, stopped_q, estop_lat_q;
    logic             at_target_d;

    assign tick = (cnt_q == CNT_W'(PERIOD - 1));

    // Next state; the slew units see this value so a tick in a transition cycle uses the new rules.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mtr_en && !estop && !estop_lat_q) state_d = RUN;
            RUN:     if (!mtr_en || estop) state_d = BRAKE;
            BRAKE:   if (tick && lft_spd == '0 && rght_spd == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        at_target_d = (state_d == RUN)
                   && (lft_spd == spd_clamp(tgt_lft, SPD_LIM))
                   && (rght_spd == spd_clamp(tgt_rght, SPD_LIM));
    end

    // Tick counter, state, e-stop latch and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            at_target_q <= 1'b0;
            stopped_q   <= 1'b1;
            estop_lat_q <= 1'b0;
        end else begin
            cnt_q       <= tick ? '0 : cnt_q + CNT_W'(1);
            state_q     <= state_d;
            at_target_q <= at_target_d;
            stopped_q   <= (state_d == IDLE);
            // Clearing needs IDLE with enable low, forcing a deliberate re-enable.
            if (estop) begin
                estop_lat_q <= 1'b1;
            end else if (state_q == IDLE && !mtr_en) begin
                estop_lat_q <= 1'b0;
            end
        end
    end

    mtr_slew #(
        .STEP        (STEP),
        .BRK_STEP    (BRK_STEP),
        .SPD_LIM     (SPD_LIM),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_slew_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .mode   (state_d),
        .target (tgt_lft),
        .cur    (lft_spd)
    );

    mtr_slew #(
        .STEP        (STEP),
        .BRK_STEP    (BRK_STEP),
        .SPD_LIM     (SPD_LIM),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_slew_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .mode   (state_d),
        .target (tgt_rght),
        .cur    (rght_spd)
    );

    assign at_target = at_target_q;
    assign stopped   = stopped_q;
    assign estop_lat = estop_lat_q;

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Bench for the motor speed ramp controller: directed scenarios plus random stimulus.
// Latency: outputs compared every cycle against a tick-level behavioural model.
// Backpressure: n/a.
module tb_mtr_ramp_ctrl;
    import mtr_pkg::*;

    localparam int TB_PERIOD = 32;
    localparam int STEP      = 16;
    localparam int BRK       = 64;
    localparam int LIM       = 1000;
    localparam int DWELL     = 4;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_BRK     = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic mtr_en;
    logic estop;
    logic signed [SPD_W-1:0] tgt_lft;
    logic signed [SPD_W-1:0] tgt_rght;
    logic signed [SPD_W-1:0] lft_spd;
    logic signed [SPD_W-1:0] rght_spd;
    logic at_target;
    logic stopped;
    logic estop_lat;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    int m_cnt, m_mode, m_l, m_r, m_dl, m_dr;
    bit m_at, m_stop, m_lat;

    int exp_up_l[7]  = '{16, 32, 48, 64, 80, 96, 100};
    int exp_up_r[7]  = '{-16, -32, -40, -40, -40, -40, -40};
    int exp_rev[8]   = '{16, 0, 0, 0, 0, 0, -16, -32};
    int exp_brk_l[8] = '{436, 372, 308, 244, 180, 116, 52, 0};
    int exp_brk_r[8] = '{-136, -72, -8, 0, 0, 0, 0, 0};

    mtr_ramp_ctrl #(
        .PERIOD      (TB_PERIOD),
        .STEP        (STEP),
        .BRK_STEP    (BRK),
        .SPD_LIM     (LIM),
        .DWELL_TICKS (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mtr_en    (mtr_en),
        .estop     (estop),
        .tgt_lft   (tgt_lft),
        .tgt_rght  (tgt_rght),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .at_target (at_target),
        .stopped   (stopped),
        .estop_lat (estop_lat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // One wheel over one tick, from the written rules: dwell first, then move
    // toward the goal by at most the step, never jumping over zero.
    task automatic wheel(input int cur, input int dw, input int tgt, input int md,
                         output int ncur, output int ndw);
        int goal, lim;
        ncur = cur;
        ndw  = dw;
        if (dw > 0) begin
            ndw = dw - 1;
        end else if (md != M_IDLE) begin
            goal = (md == M_BRK) ? 0 : clampv(tgt);
            lim  = (md == M_BRK) ? BRK : STEP;
            if (goal - cur > lim)      ncur = cur + lim;
            else if (cur - goal > lim) ncur = cur - lim;
            else                       ncur = goal;
            if ((cur > 0 && ncur < 0) || (cur < 0 && ncur > 0)) ncur = 0;
            if (cur != 0 && ncur == 0) ndw = DWELL;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : mdl
        int nm, nl, nr, ndl, ndr;
        bit tk;
        if (!rst_n) begin
            m_cnt  <= 0;
            m_mode <= M_IDLE;
            m_l    <= 0;
            m_r    <= 0;
            m_dl   <= 0;
            m_dr   <= 0;
            m_at   <= 1'b0;
            m_stop <= 1'b1;
            m_lat  <= 1'b0;
        end else begin
            tk = (m_cnt == TB_PERIOD - 1);
            nm = m_mode;
            if (m_mode == M_IDLE && mtr_en && !estop && !m_lat)       nm = M_RUN;
            else if (m_mode == M_RUN && (!mtr_en || estop))           nm = M_BRK;
            else if (m_mode == M_BRK && tk && m_l == 0 && m_r == 0)   nm = M_IDLE;
            nl = m_l; nr = m_r; ndl = m_dl; ndr = m_dr;
            if (tk) begin
                wheel(m_l, m_dl, int'(tgt_lft), nm, nl, ndl);
                wheel(m_r, m_dr, int'(tgt_rght), nm, nr, ndr);
            end
            m_cnt  <= tk ? 0 : m_cnt + 1;
            m_mode <= nm;
            m_l    <= nl;
            m_r    <= nr;
            m_dl   <= ndl;
            m_dr   <= ndr;
            m_stop <= (nm == M_IDLE);
            m_at   <= (nm == M_RUN) && (m_l == clampv(int'(tgt_lft)))
                                    && (m_r == clampv(int'(tgt_rght)));
            if (estop)                             m_lat <= 1'b1;
            else if (m_mode == M_IDLE && !mtr_en)  m_lat <= 1'b0;
        end
    end

    // Every cycle: DUT against the model.
    always @(negedge clk) begin
        chk("mdl_lft",  int'(lft_spd),  m_l);
        chk("mdl_rght", int'(rght_spd), m_r);
        chk("mdl_at",   int'(at_target), int'(m_at));
        chk("mdl_stop", int'(stopped),   int'(m_stop));
        chk("mdl_lat",  int'(estop_lat), int'(m_lat));
    end

    // Advance to the negedge just after the next tick edge.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != 0 && n <= TB_PERIOD + 2);
        if (m_cnt != 0) chk("tick_timeout", 1, 0);
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) wait_tick();
    endtask

    // Advance to the negedge where the counter holds v (the coming edge is then tick if v = PERIOD-1).
    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != v && n <= TB_PERIOD + 2);
        if (m_cnt != v) chk("cnt_timeout", 1, 0);
    endtask

    initial begin : stim
        int peak, hold, mid;
        rst_n = 1'b0; mtr_en = 1'b0; estop = 1'b0; tgt_lft = '0; tgt_rght = '0;
        repeat (3) @(negedge clk);
        chk("rst_lft",  int'(lft_spd), 0);
        chk("rst_rght", int'(rght_spd), 0);
        chk("rst_at",   int'(at_target), 0);
        chk("rst_stop", int'(stopped), 1);
        chk("rst_lat",  int'(estop_lat), 0);
        rst_n = 1'b1;

        // Ramp-up
        wait_tick();
        mtr_en = 1'b1; tgt_lft = 11'sd100; tgt_rght = -11'sd40;
        for (int i = 0; i < 7; i++) begin
            wait_tick();
            chk("up_lft", int'(lft_spd), exp_up_l[i]);
            chk("up_rght", int'(rght_spd), exp_up_r[i]);
            if (i == 2) begin
                repeat (TB_PERIOD / 2) @(negedge clk);
                chk("up_hold", int'(lft_spd), exp_up_l[i]);
            end
        end
        chk("up_at_edge", int'(at_target), 0);
        @(negedge clk);
        chk("up_at_next", int'(at_target), 1);

        // Clamp, positive then negative
        tgt_lft = 11'sd1023; peak = 0;
        for (int i = 0; i < 70; i++) begin
            wait_tick();
            if (int'(lft_spd) > peak) peak = int'(lft_spd);
        end
        chk("clamp_pos", int'(lft_spd), 1000);
        chk("clamp_pos_peak", peak, 1000);
        tgt_lft = -11'sd1024; peak = 0;
        for (int i = 0; i < 140; i++) begin
            wait_tick();
            if (int'(lft_spd) < peak) peak = int'(lft_spd);
        end
        chk("clamp_neg", int'(lft_spd), -1000);
        chk("clamp_neg_peak", peak, -1000);

        // Reversal with dwell
        tgt_lft = 11'sd32;
        wait_ticks(75);
        chk("rev_start", int'(lft_spd), 32);
        tgt_lft = -11'sd32;
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            chk("rev_seq", int'(lft_spd), exp_rev[i]);
        end

        // E-stop brake
        tgt_lft = 11'sd500; tgt_rght = -11'sd200;
        wait_ticks(45);
        chk("es_pre_l", int'(lft_spd), 500);
        chk("es_pre_r", int'(rght_spd), -200);
        estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        chk("es_lat", int'(estop_lat), 1);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            chk("brk_l", int'(lft_spd), exp_brk_l[i]);
            chk("brk_r", int'(rght_spd), exp_brk_r[i]);
        end
        wait_tick();
        chk("es_idle", int'(stopped), 1);
        chk("es_lat_hold", int'(estop_lat), 1);
        wait_ticks(3);
        chk("es_stay_idle", int'(stopped), 1);
        mtr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("es_lat_clr", int'(estop_lat), 0);
        mtr_en = 1'b1;
        @(negedge clk);
        chk("es_rerun", int'(stopped), 0);

        // Disable in the same cycle as a tick
        tgt_lft = 11'sd300; tgt_rght = '0;
        wait_ticks(25);
        chk("col_pre", int'(lft_spd), 300);
        wait_cnt(TB_PERIOD - 1);
        mtr_en = 1'b0;
        @(negedge clk);
        chk("col_brk", int'(lft_spd), 236);

        // Asynchronous reset mid-ramp
        mtr_en = 1'b1; tgt_lft = 11'sd200;
        wait_ticks(30);
        chk("ar_pre", int'(lft_spd), 200);
        mid = TB_PERIOD / 2;
        wait_cnt(mid);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_lft", int'(lft_spd), 0);
        chk("ar_stop", int'(stopped), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TB_PERIOD - 1) @(negedge clk);
        chk("ar_no_tick", int'(lft_spd), 0);
        @(negedge clk);
        chk("ar_first_tick", int'(lft_spd), 16);

        // Random stimulus against the model
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0)
                tgt_lft = spd_t'($urandom_range(0, 2047));
            else if ($urandom_range(0, 2) == 0)
                tgt_lft = spd_t'(int'($urandom_range(0, 600)) - 300);
            if ($urandom_range(0, 3) == 0)
                tgt_rght = spd_t'($urandom_range(0, 2047));
            else if ($urandom_range(0, 2) == 0)
                tgt_rght = spd_t'(int'($urandom_range(0, 600)) - 300);
            if ($urandom_range(0, 7) == 0) mtr_en = ~mtr_en;
            if ($urandom_range(0, 19) == 0) begin
                estop = 1'b1;
                @(negedge clk);
                estop = 1'b0;
            end
            hold = int'($urandom_range(1, 80));
            repeat (hold) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
